wire_test2: RTL and testbench
=============================

// Module: wire_test2
// PURPOSE
//   Clocked two-input logic-pair cell: samples single-bit inputs W and X and drives
//   two registered logic results, Y and Z, selected by a function-select port.
//   Also counts input-pattern transitions for lab and bring-up observation.
//   Sits between stimulus/switch logic and downstream display or compare logic.
// PARAMETERS
//   CNT_W     8    width of the transition counter trans_cnt
// PORTS
//   clk        in   1       single clock; all state updates on rising edge
//   rst_n      in   1       asynchronous active-low reset
//   W          in   1       logic operand A
//   X          in   1       logic operand B
//   mode       in   2       function select, sampled every cycle (see BEHAVIOUR)
//   cnt_clr    in   1       synchronous clear of trans_cnt
//   Y          out  1       registered primary result
//   Z          out  1       registered secondary result
//   y_comb     out  1       combinational primary result (same function as Y, no register)
//   z_comb     out  1       combinational secondary result
//   trans_cnt  out  CNT_W   number of cycles in which {W,X} differed from previous sample
// BEHAVIOUR
//   Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//   Reset (rst_n=0, asynchronous assert, released synchronously to clk):
//     Y=0, Z=0, trans_cnt=0, previous-sample register {W,X}_prev=2'b00.
//     y_comb and z_comb remain combinational during reset.
//   Function table, mode -> (y_comb, z_comb):
//     2'b00: (W & X,    W | X)     default lab function
//     2'b01: (~(W & X), ~(W | X))
//     2'b10: (W ^ X,    ~(W ^ X))
//     2'b11: (W,        X)         pass-through
//   Latency: Y and Z equal y_comb and z_comb as sampled at the previous rising clk edge.
//     Latency is exactly 1 cycle and there is no handshake.
//   Mode change: takes effect on the first edge after mode changes.
//     Mode has no hidden state and no pipeline flush.
//   Transition counter:
//     A transition is a cycle where the sampled {W,X} != {W,X}_prev.
//     {W,X}_prev updates every cycle.
//     trans_cnt increments by 1 per transition, whether one or both bits change.
//     trans_cnt saturates at all-ones and does not wrap.
//     cnt_clr=1 forces trans_cnt to 0 next edge and takes priority over a simultaneous increment.
//     The transition in a clear cycle is discarded, but {W,X}_prev still updates.
//     First sample after reset is compared against 2'b00.
//   Reset mid-operation: all registers return to their reset values immediately.
//     No count is preserved.
//   Inputs are treated as synchronous to clk; no internal synchronizer.
// TESTING
//   1. rst_n=0 with W=1, X=1 -> Y=0, Z=0, trans_cnt=0 while held.
//      y_comb=1, z_comb=1 (mode 00).
//   2. mode=00, clk 10ns; W,X = 00,10,11,01,00, each held 20ns:
//      Y -> 0,0,1,0,0 and Z -> 0,1,1,1,0, one cycle after each input change.
//      trans_cnt=4 at end.
//   3. Sweep mode 01/10/11 over all four {W,X} combinations -> Y/Z match the table.
//      Example: mode=10, W=1, X=1 -> Y=0, Z=1.
//   4. CNT_W=2, toggle W every cycle for 6 cycles -> trans_cnt 1,2,3,3,3,3 (saturates).
//   5. cnt_clr=1 in a cycle where W changes -> trans_cnt=0 next edge.
//      The next changing cycle gives trans_cnt=1.
//   6. Assert rst_n=0 between edges with trans_cnt=3 -> trans_cnt, Y, Z go to 0
//      immediately, without waiting for clk.

Source files
------------

// File: rtl/wire_test2.sv
// -----------------------------------------------------------------------------
// wire_test2
//   Clocked two-input logic-pair cell. Operands W and X go through a
//   mode-selected function pair. The pair is available combinationally on
//   y_comb/z_comb and registered once on Y/Z. A saturating counter records how
//   many sampled cycles saw {W,X} change from the previous sample.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   W          in   1      logic operand A
//   X          in   1      logic operand B
//   mode       in   2      function select: 00 and/or, 01 nand/nor,
//                          10 xor/xnor, 11 pass-through W/X
//   cnt_clr    in   1      synchronous clear of trans_cnt; wins over increment
//   Y          out  1      registered primary result (1-cycle latency)
//   Z          out  1      registered secondary result (1-cycle latency)
//   y_comb     out  1      combinational primary result
//   z_comb     out  1      combinational secondary result
//   trans_cnt  out  CNT_W  saturating count of {W,X} transitions
// -----------------------------------------------------------------------------
module wire_test2 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             W,
    input  logic             X,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic             Y,
    output logic             Z,
    output logic             y_comb,
    output logic             z_comb,
    output logic [CNT_W-1:0] trans_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0] wx;
    logic [1:0] wx_prev;
    logic       is_trans;

    assign wx       = {W, X};
    assign is_trans = (wx != wx_prev);

    always_comb begin
        y_comb = 1'b0;
        z_comb = 1'b0;
        case (mode)
            2'b00: begin
                y_comb = W & X;
                z_comb = W | X;
            end
            2'b01: begin
                y_comb = ~(W & X);
                z_comb = ~(W | X);
            end
            2'b10: begin
                y_comb = W ^ X;
                z_comb = ~(W ^ X);
            end
            default: begin
                y_comb = W;
                z_comb = X;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y <= 1'b0;
            Z <= 1'b0;
        end else begin
            Y <= y_comb;
            Z <= z_comb;
        end
    end

    // The previous sample tracks every cycle, including clear cycles, so a
    // change that lands together with cnt_clr is consumed and not recounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wx_prev   <= 2'b00;
            trans_cnt <= '0;
        end else begin
            wx_prev <= wx;
            if (cnt_clr) begin
                trans_cnt <= '0;
            end else if (is_trans && (trans_cnt != CNT_MAX)) begin
                trans_cnt <= trans_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_wire_test2.sv
module tb_wire_test2;

    logic       clk;
    logic       rst_n;
    logic       W, X;
    logic [1:0] mode;
    logic       cnt_clr;
    logic       Y, Z, y_comb, z_comb;
    logic [7:0] trans_cnt;

    // narrow-counter instance for saturation
    logic       w2, x2, clr2;
    logic       y2, z2, yc2, zc2;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    wire_test2 #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .W(W), .X(X), .mode(mode), .cnt_clr(cnt_clr),
        .Y(Y), .Z(Z), .y_comb(y_comb), .z_comb(z_comb), .trans_cnt(trans_cnt)
    );

    wire_test2 #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .W(w2), .X(x2), .mode(2'b00), .cnt_clr(clr2),
        .Y(y2), .Z(z2), .y_comb(yc2), .z_comb(zc2), .trans_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; W = 1'b1; X = 1'b1; mode = 2'b00; cnt_clr = 1'b0;
        w2 = 1'b0; x2 = 1'b0; clr2 = 1'b0;
        #3;
        total++;
        if (Y !== 1'b0 || Z !== 1'b0) begin
            bad++; $display("FAIL reset_yz: got Y=%b Z=%b want 0 0", Y, Z);
        end
        total++;
        if (trans_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_cnt: got %0d want 0", trans_cnt);
        end
        total++;
        if (y_comb !== 1'b1 || z_comb !== 1'b1) begin
            bad++; $display("FAIL reset_comb: got y_comb=%b z_comb=%b want 1 1", y_comb, z_comb);
        end
        repeat (2) tick();
        total++;
        if (Y !== 1'b0 || Z !== 1'b0 || trans_cnt !== 8'd0 || cnt2 !== 2'd0) begin
            bad++; $display("FAIL reset_held: got Y=%b Z=%b cnt=%0d cnt2=%0d want 0 0 0 0",
                            Y, Z, trans_cnt, cnt2);
        end
        W = 1'b0; X = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_pattern();
        logic [1:0] pat [5];
        logic [4:0] exp_y;
        logic [4:0] exp_z;
        pat[0] = 2'b00; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b01; pat[4] = 2'b00;
        exp_y = 5'b00100;   // bit i = Y after pattern i
        exp_z = 5'b01110;
        mode = 2'b00;
        tick();
        for (int i = 0; i < 5; i++) begin
            {W, X} = pat[i];
            if (i == 2) begin
                #1;
                total++;
                if (Y !== 1'b0) begin
                    bad++; $display("FAIL latency_before_edge: got Y=%b want 0", Y);
                end
            end
            tick();
            total++;
            if (Y !== exp_y[i] || Z !== exp_z[i]) begin
                bad++; $display("FAIL pattern%0d: got Y=%b Z=%b want %b %b",
                                i, Y, Z, exp_y[i], exp_z[i]);
            end
            tick();
        end
        total++;
        if (trans_cnt !== 8'd4) begin
            bad++; $display("FAIL pattern_cnt: got %0d want 4", trans_cnt);
        end
    endtask

    task automatic test_modes();
        logic [3:0] ty [4];
        logic [3:0] tz [4];
        // bit i = expected result for {W,X} = i
        ty[1] = 4'b0111; tz[1] = 4'b0001;
        ty[2] = 4'b0110; tz[2] = 4'b1001;
        ty[3] = 4'b1100; tz[3] = 4'b1010;
        ty[0] = 4'b1000; tz[0] = 4'b1110;
        for (int m = 1; m < 4; m++) begin
            for (int v = 0; v < 4; v++) begin
                mode = m[1:0];
                {W, X} = v[1:0];
                #1;
                total++;
                if (y_comb !== ty[m][v] || z_comb !== tz[m][v]) begin
                    bad++; $display("FAIL comb_m%0d_wx%0d: got %b %b want %b %b",
                                    m, v, y_comb, z_comb, ty[m][v], tz[m][v]);
                end
                tick();
                total++;
                if (Y !== ty[m][v] || Z !== tz[m][v]) begin
                    bad++; $display("FAIL reg_m%0d_wx%0d: got Y=%b Z=%b want %b %b",
                                    m, v, Y, Z, ty[m][v], tz[m][v]);
                end
            end
        end
        // mode change alone, inputs steady: new function on the very next edge
        W = 1'b1; X = 1'b1; mode = 2'b10;
        tick();
        mode = 2'b00;
        tick();
        total++;
        if (Y !== 1'b1 || Z !== 1'b1) begin
            bad++; $display("FAIL mode_switch: got Y=%b Z=%b want 1 1", Y, Z);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_c [6];
        exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3;
        exp_c[3] = 2'd3; exp_c[4] = 2'd3; exp_c[5] = 2'd3;
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w2 = ~w2;
            tick();
            total++;
            if (cnt2 !== exp_c[i]) begin
                bad++; $display("FAIL saturate%0d: got %0d want %0d", i, cnt2, exp_c[i]);
            end
        end
    endtask

    task automatic test_clear();
        W = 1'b0; X = 1'b0;
        tick();
        W = 1'b1; cnt_clr = 1'b1;
        tick();
        total++;
        if (trans_cnt !== 8'd0) begin
            bad++; $display("FAIL clear: got %0d want 0", trans_cnt);
        end
        cnt_clr = 1'b0;
        tick();
        total++;
        if (trans_cnt !== 8'd0) begin
            bad++; $display("FAIL clear_prev_update: got %0d want 0", trans_cnt);
        end
        W = 1'b0;
        tick();
        total++;
        if (trans_cnt !== 8'd1) begin
            bad++; $display("FAIL after_clear: got %0d want 1", trans_cnt);
        end
    endtask

    task automatic test_async_reset();
        mode = 2'b11;
        W = 1'b1; tick();
        X = 1'b1; tick();
        total++;
        if (trans_cnt !== 8'd3 || Y !== 1'b1 || Z !== 1'b1) begin
            bad++; $display("FAIL pre_reset: got cnt=%0d Y=%b Z=%b want 3 1 1", trans_cnt, Y, Z);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (trans_cnt !== 8'd0 || Y !== 1'b0 || Z !== 1'b0 || cnt2 !== 2'd0) begin
            bad++; $display("FAIL async_reset: got cnt=%0d Y=%b Z=%b cnt2=%0d want 0 0 0 0",
                            trans_cnt, Y, Z, cnt2);
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_modes();
        test_saturate();
        test_clear();
        test_async_reset();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
